// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//
// Purpose:
//   Bundles every request, ALU-drive and response signal of alu_arbiter.
//   The clock and reset stay outside the bundle as plain module ports.
//
// Modports:
//   slave  - the arbiter. It receives the requests and alu_s, and drives the
//            ready signals, the ALU operands, the responses, busy and
//            dbg_state.
//   master - the environment. It holds both requesters, the ALU and the
//            response sinks.
//
// Handshake rule:
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source that raises valid holds it, and holds its payload stable, until
//   that transfer happens. ready may depend combinationally on valid.
//   This rule applies to req0/req1 (valid in, ready out) and to rsp0/rsp1
//   (valid out, ready in).
//
// Signals:
//   req{0,1}_valid/ready   request handshake per requester
//   req{0,1}_a/_b [31:0]   operands
//   req{0,1}_cfg [11:0]    {c_0, Const_Var, shift_direction,
//                           Function_class[1:0], Logic_function[1:0],
//                           Const_amount[4:0]}
//   alu_a/_b [31:0]        operands driven to the shared ALU
//   alu_cfg [11:0]         ALU control, with the same packing as req*_cfg
//   alu_s [31:0]           ALU result, a combinational function of alu_*
//   rsp{0,1}_valid/ready   response handshake per requester
//   rsp_data [31:0]        the shared result register
//   busy                   high whenever the arbiter is not idle
//   dbg_state [1:0]        the current FSM state, for observation
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [11:0] req0_cfg;
    logic [11:0] req1_cfg;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_cfg;
    logic [31:0] alu_s;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_cfg, req1_cfg, alu_s, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_cfg,
        output rsp0_valid, rsp1_valid, rsp_data, busy, dbg_state
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_cfg, req1_cfg, alu_s, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_cfg,
        input  rsp0_valid, rsp1_valid, rsp_data, busy, dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational 32-bit ALU between two requesters.
//   Only one operation is in flight at a time. Each operation passes through
//   three states:
//     IDLE - accept one request and latch its operands into the ALU-drive
//            registers.
//     EXEC - wait one cycle for alu_s to settle, then capture it.
//     RESP - present the result to the granted requester until it is taken.
//   The block performs no arithmetic itself: rsp_data is alu_s copied
//   bit-for-bit.
//
// Ports:
//   clk  - the single clock; all state updates on its rising edge.
//   rst  - asynchronous, active-high reset. It aborts any operation in
//          flight, and the aborted result is never presented.
//   bus  - alu_arbiter_if.slave, carrying the requests, ALU drive, responses,
//          busy and dbg_state.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN
//     Defined:   requester 0 always wins contention.
//     Undefined: round-robin. When both requesters are valid, the one not
//                served last is granted. After reset, requester 0 wins the
//                first contention.
// ---------------------------------------------------------------------------
module alu_arbiter (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;            // requester owning the op in flight
    logic        last_grant_q, last_grant_d;  // requester whose response completed last
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [11:0] alu_cfg_q, alu_cfg_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic        busy_q, busy_d;

    logic        any_valid;
    logic        grant_sel;   // requester that would be granted this cycle
    logic        rsp_ack;     // the granted requester takes its result

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
        // Requester 1 wins only when requester 0 is not asking.
        grant_sel = ~bus.req0_valid;
`else
        // Under contention, grant the requester not served last.
        // A lone requester always wins.
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = bus.req1_valid;
        end
`endif

        // Only the granted requester's ready counts.
        rsp_ack = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cfg_d    = alu_cfg_q;
        rsp_data_d   = rsp_data_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d   = grant_sel;
                    alu_a_d   = grant_sel ? bus.req1_a   : bus.req0_a;
                    alu_b_d   = grant_sel ? bus.req1_b   : bus.req0_b;
                    alu_cfg_d = grant_sel ? bus.req1_cfg : bus.req0_cfg;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had one full cycle to settle on alu_a/b/cfg.
                rsp_data_d   = bus.alu_s;
                rsp0_valid_d = ~grant_q;
                rsp1_valid_d = grant_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ack) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_cfg_q    <= 12'd0;
            rsp_data_q   <= 32'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cfg_q    <= alu_cfg_d;
            rsp_data_q   <= rsp_data_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Ready is combinational in IDLE and is forced low while rst is held.
    // Forcing it low keeps an acceptance from being signalled that the
    // held-in-reset registers would not take.
    assign bus.req0_ready = (state_q == IDLE) && !rst && bus.req0_valid && !grant_sel;
    assign bus.req1_ready = (state_q == IDLE) && !rst && bus.req1_valid &&  grant_sel;

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cfg    = alu_cfg_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state_q;

endmodule
